// File: rtl/dbg_pkg.sv
// Shared types and constants for the JTAG debug transport module.
package dbg_pkg;

  localparam int unsigned IrWidth    = 5;
  localparam int unsigned DtmcsWidth = 32;

  // Instruction register opcodes
  localparam logic [IrWidth-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IrWidth-1:0] IR_DTMCS   = 5'h10;
  localparam logic [IrWidth-1:0] IR_DMI     = 5'h11;
  localparam logic [IrWidth-1:0] IR_BYPASS  = 5'h1f;
  localparam logic [IrWidth-1:0] IR_CAPTURE = 5'b00001;

  // dtmcs write-side control bits
  localparam int unsigned DmiResetBit     = 16;
  localparam int unsigned DmiHardResetBit = 17;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    STAT_OK     = 2'd0,
    STAT_RSVD   = 2'd1,
    STAT_FAILED = 2'd2,
    STAT_BUSY   = 2'd3
  } dmi_status_e;

  typedef enum logic [3:0] {
    TAP_RESET,
    TAP_IDLE,
    TAP_SEL_DR,
    TAP_CAPTURE_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPDATE_DR,
    TAP_SEL_IR,
    TAP_CAPTURE_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPDATE_IR
  } tap_state_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

endpackage

// File: rtl/jtag_pin_sync.sv
// Synchronizes the JTAG pins into the SoC clock domain and derives TCK edge strobes.
module jtag_pin_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trst_n,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_n_s,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  logic [SyncStages-1:0] tck_sr;
  logic [SyncStages-1:0] tms_sr;
  logic [SyncStages-1:0] tdi_sr;
  logic [SyncStages-1:0] trst_sr;
  logic                  tck_prev;

  // Synchronizer chains; all pins share the same depth so TMS/TDI stay aligned with TCK
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sr   <= '0;
      tms_sr   <= '0;
      tdi_sr   <= '0;
      trst_sr  <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sr   <= {tck_sr[SyncStages-2:0], tck};
      tms_sr   <= {tms_sr[SyncStages-2:0], tms};
      tdi_sr   <= {tdi_sr[SyncStages-2:0], tdi};
      trst_sr  <= {trst_sr[SyncStages-2:0], trst_n};
      tck_prev <= tck_sr[SyncStages-1];
    end
  end

  assign tms_s      = tms_sr[SyncStages-1];
  assign tdi_s      = tdi_sr[SyncStages-1];
  assign trst_n_s   = trst_sr[SyncStages-1];
  assign tck_rise_c = tck_sr[SyncStages-1] & ~tck_prev;
  assign tck_fall_c = ~tck_sr[SyncStages-1] & tck_prev;

endmodule

// File: rtl/jtag_dmi_responder.sv
// JTAG TAP plus RISC-V DTM, oversampled on clk_i, bridging DMI scans to a valid/ready interface.
module jtag_dmi_responder
  import dbg_pkg::*;
#(
  parameter logic [31:0] IdcodeValue = 32'h1c5e5db3,
  parameter int unsigned AddrWidth   = 7,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jtag_tck_i,
  input  logic                 jtag_tms_i,
  input  logic                 jtag_tdi_i,
  input  logic                 jtag_trst_ni,
  output logic                 jtag_tdo_o,
  output logic                 jtag_tdo_oe_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [1:0]           dmi_req_op_o,
  output logic [31:0]          dmi_req_data_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic                 dmi_resp_err_i
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  logic tms_s, tdi_s, trst_n_s, tck_rise, tck_fall;
  logic tap_rst;

  tap_state_e tap_q, tap_d;
  logic [IrWidth-1:0] ir_q, ir_sr_q;
  logic [DrWidth-1:0] dr_q, dr_cap, dr_shift;
  dtmcs_t             dtmcs_cap;
  logic [1:0]         cap_op;
  logic               shifting;

  logic                 tdo_q, tdo_oe_q;
  logic [1:0]           sticky_q;
  logic                 req_valid_q, resp_pend_q, resp_ready_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q, rdata_q;
  logic [1:0]           op_q;
  logic                 busy;

  jtag_pin_sync #(.SyncStages(SyncStages)) u_pin_sync (
    .clk        (clk_i),
    .rst        (rst_i),
    .tck        (jtag_tck_i),
    .tms        (jtag_tms_i),
    .tdi        (jtag_tdi_i),
    .trst_n     (jtag_trst_ni),
    .tms_s      (tms_s),
    .tdi_s      (tdi_s),
    .trst_n_s   (trst_n_s),
    .tck_rise_c (tck_rise),
    .tck_fall_c (tck_fall)
  );

  assign tap_rst  = rst_i | ~trst_n_s;
  assign busy     = req_valid_q | resp_pend_q;
  assign shifting = (tap_q == TAP_SHIFT_DR) || (tap_q == TAP_SHIFT_IR);

  // TAP state register, advanced on each synchronized TCK rising edge
  always_ff @(posedge clk_i) begin
    if (tap_rst) begin
      tap_q <= TAP_RESET;
    end else if (tck_rise) begin
      tap_q <= tap_d;
    end
  end

  // IEEE 1149.1 next-state decode
  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TAP_RESET:      tap_d = tms_s ? TAP_RESET      : TAP_IDLE;
      TAP_IDLE:       tap_d = tms_s ? TAP_SEL_DR     : TAP_IDLE;
      TAP_SEL_DR:     tap_d = tms_s ? TAP_SEL_IR     : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: tap_d = tms_s ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   tap_d = tms_s ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   tap_d = tms_s ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   tap_d = tms_s ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   tap_d = tms_s ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  tap_d = tms_s ? TAP_SEL_DR     : TAP_IDLE;
      TAP_SEL_IR:     tap_d = tms_s ? TAP_RESET      : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: tap_d = tms_s ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   tap_d = tms_s ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   tap_d = tms_s ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   tap_d = tms_s ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   tap_d = tms_s ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  tap_d = tms_s ? TAP_SEL_DR     : TAP_IDLE;
      default:        tap_d = TAP_RESET;
    endcase
  end

  // Instruction register: capture, shift and update
  always_ff @(posedge clk_i) begin
    if (tap_rst) begin
      ir_q    <= IR_IDCODE;
      ir_sr_q <= '0;
    end else if (tap_q == TAP_RESET) begin
      ir_q <= IR_IDCODE;
    end else if (tck_rise) begin
      case (tap_q)
        TAP_CAPTURE_IR: ir_sr_q <= IR_CAPTURE;
        TAP_SHIFT_IR:   ir_sr_q <= {tdi_s, ir_sr_q[IrWidth-1:1]};
        TAP_UPDATE_IR:  ir_q    <= ir_sr_q;
        default: ;
      endcase
    end
  end

  // Capture and shift values of the selected data register
  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.version = 4'd1;
    dtmcs_cap.abits   = 6'(AddrWidth);
    dtmcs_cap.dmistat = sticky_q;
    dtmcs_cap.idle    = 3'd1;

    cap_op = 2'(STAT_OK);
    if (sticky_q != 2'(STAT_OK)) cap_op = sticky_q;
    else if (busy)               cap_op = 2'(STAT_BUSY);

    case (ir_q)
      IR_IDCODE: dr_cap = DrWidth'(IdcodeValue);
      IR_DTMCS:  dr_cap = DrWidth'(dtmcs_cap);
      IR_DMI:    dr_cap = {addr_q, rdata_q, cap_op};
      default:   dr_cap = '0;
    endcase

    case (ir_q)
      IR_IDCODE, IR_DTMCS: dr_shift = DrWidth'({tdi_s, dr_q[DtmcsWidth-1:1]});
      IR_DMI:              dr_shift = {tdi_s, dr_q[DrWidth-1:1]};
      default:             dr_shift = DrWidth'(tdi_s);
    endcase
  end

  // Data register scans, DTMCS/DMI update actions and the DMI request/response handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dr_q         <= '0;
      sticky_q     <= 2'(STAT_OK);
      req_valid_q  <= 1'b0;
      resp_pend_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      rdata_q      <= '0;
    end else begin
      resp_ready_q <= 1'b1;

      if (req_valid_q && dmi_req_ready_i) begin
        req_valid_q <= 1'b0;
        resp_pend_q <= 1'b1;
      end

      if (resp_pend_q && dmi_resp_valid_i) begin
        resp_pend_q <= 1'b0;
        rdata_q     <= dmi_resp_data_i;
        if (dmi_resp_err_i && sticky_q == 2'(STAT_OK)) sticky_q <= 2'(STAT_FAILED);
      end

      if (tap_rst) begin
        dr_q <= '0;
      end else if (tck_rise) begin
        case (tap_q)
          TAP_CAPTURE_DR: begin
            dr_q <= dr_cap;
            if (ir_q == IR_DMI && sticky_q == 2'(STAT_OK) && busy) sticky_q <= 2'(STAT_BUSY);
          end
          TAP_SHIFT_DR: dr_q <= dr_shift;
          TAP_UPDATE_DR: begin
            if (ir_q == IR_DTMCS) begin
              if (dr_q[DmiResetBit] || dr_q[DmiHardResetBit]) sticky_q <= 2'(STAT_OK);
              if (dr_q[DmiHardResetBit]) begin
                req_valid_q <= 1'b0;
                resp_pend_q <= 1'b0;
              end
            end else if (ir_q == IR_DMI) begin
              if (busy) begin
                sticky_q <= 2'(STAT_BUSY);
              end else if ((dr_q[1:0] == 2'(OP_READ) || dr_q[1:0] == 2'(OP_WRITE)) &&
                           sticky_q == 2'(STAT_OK)) begin
                req_valid_q <= 1'b1;
                addr_q      <= dr_q[DrWidth-1:34];
                wdata_q     <= dr_q[33:2];
                op_q        <= dr_q[1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // TDO launches on TCK falling edges; enable drops as soon as the TAP leaves a shift state
  always_ff @(posedge clk_i) begin
    if (tap_rst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else if (!shifting) begin
      tdo_oe_q <= 1'b0;
    end else if (tck_fall) begin
      tdo_oe_q <= 1'b1;
      tdo_q    <= (tap_q == TAP_SHIFT_IR) ? ir_sr_q[0] : dr_q[0];
    end
  end

  assign jtag_tdo_o       = tdo_q;
  assign jtag_tdo_oe_o    = tdo_oe_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_req_data_o   = wdata_q;
  assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_jtag_dmi_responder.sv
// Directed + randomized bench for jtag_dmi_responder with a transaction-level DTM model.
module tb_jtag_dmi_responder;

  localparam logic [31:0] IDCODE = 32'h1c5e5db3;
  localparam int          AW     = 7;

  logic        clk = 1'b0;
  logic        rst, tck, tms, tdi, trst_n, tdo, tdo_oe;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data, resp_data;

  int tests = 0;
  int fails = 0;
  int oe_bad;

  // Transaction-level model of the DTM status
  logic [1:0]  m_sticky;
  bit          m_busy;
  logic [6:0]  m_addr;
  logic [31:0] m_rdata;
  logic [1:0]  m_req_op;
  logic [31:0] m_req_data;

  always #5 clk = ~clk;

  jtag_dmi_responder dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .jtag_tck_i       (tck),
    .jtag_tms_i       (tms),
    .jtag_tdi_i       (tdi),
    .jtag_trst_ni     (trst_n),
    .jtag_tdo_o       (tdo),
    .jtag_tdo_oe_o    (tdo_oe),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_ready_i  (req_ready),
    .dmi_req_addr_o   (req_addr),
    .dmi_req_op_o     (req_op),
    .dmi_req_data_o   (req_data),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_ready_o (resp_ready),
    .dmi_resp_data_i  (resp_data),
    .dmi_resp_err_i   (resp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK period of 8 clk cycles; TDO/OE sampled just before the rising edge
  task automatic tck_cycle(input logic t_ms, input logic t_di, input logic exp_oe, output logic t_do);
    tms = t_ms;
    tdi = t_di;
    repeat (4) @(negedge clk);
    t_do = tdo;
    if (tdo_oe !== exp_oe) oe_bad++;
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic move(input logic t_ms);
    logic d;
    tck_cycle(t_ms, 1'b0, 1'b0, d);
  endtask

  task automatic shift_ir(input logic [4:0] ir);
    logic [4:0] cap;
    logic d;
    oe_bad = 0;
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, ir[i], 1'b1, d);
      cap[i] = d;
    end
    move(1'b1); move(1'b0);
    check("ir_capture", 64'(cap), 64'(5'b00001));
    check("ir_tdo_oe", 64'(oe_bad), 64'd0);
  endtask

  task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic d;
    dout   = '0;
    oe_bad = 0;
    move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], 1'b1, d);
      dout[i] = d;
    end
    move(1'b1); move(1'b0);
    check("dr_tdo_oe", 64'(oe_bad), 64'd0);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input string tag);
    logic [63:0] got;
    logic [1:0]  eop;
    eop = (m_sticky != 2'd0) ? m_sticky : (m_busy ? 2'd3 : 2'd0);
    if (m_sticky == 2'd0 && m_busy) m_sticky = 2'd3;
    shift_dr(41, {23'b0, a, d, op}, got);
    check(tag, got, {23'b0, m_addr, m_rdata, eop});
    if (m_busy) m_sticky = 2'd3;
    else if ((op == 2'd1 || op == 2'd2) && m_sticky == 2'd0) begin
      m_busy     = 1'b1;
      m_addr     = a;
      m_req_op   = op;
      m_req_data = d;
    end
  endtask

  task automatic dtmcs_scan(input logic [31:0] wr, input string tag);
    logic [63:0] got;
    logic [31:0] exp;
    exp = 32'h1000 | (32'(m_sticky) << 10) | (32'(AW) << 4) | 32'h1;
    shift_dr(32, {32'b0, wr}, got);
    check(tag, got, {32'b0, exp});
    if (wr[17]) begin m_sticky = 2'd0; m_busy = 1'b0; end
    if (wr[16]) m_sticky = 2'd0;
  endtask

  // Plays the debug module: wait for request, hold ready low, accept, then respond
  task automatic serve(input int dly, input logic [31:0] rdata, input logic err);
    int n;
    int bad;
    n = 0;
    while (req_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("req_seen", 64'(req_valid), 64'd1);
    check("req_addr", 64'(req_addr), 64'(m_addr));
    check("req_op", 64'(req_op), 64'(m_req_op));
    check("req_data", 64'(req_data), 64'(m_req_data));
    bad = 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (req_valid !== 1'b1 || req_addr !== m_addr || req_op !== m_req_op ||
          req_data !== m_req_data) bad++;
    end
    check("req_hold", 64'(bad), 64'd0);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("req_drop", 64'(req_valid), 64'd0);
    repeat (2) @(negedge clk);
    resp_valid = 1'b1; resp_data = rdata; resp_err = err;
    @(negedge clk);
    resp_valid = 1'b0; resp_err = 1'b0;
    m_busy  = 1'b0;
    m_rdata = rdata;
    if (err && m_sticky == 2'd0) m_sticky = 2'd2;
    repeat (3) @(negedge clk);
    check("no_extra_req", 64'(req_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] pat;
    logic        d;
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_err = 1'b0;
    m_sticky = 2'd0; m_busy = 1'b0; m_addr = '0; m_rdata = '0; m_req_op = '0; m_req_data = '0;
    oe_bad = 0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_outputs", 64'({tdo, tdo_oe, req_valid, req_addr, req_op, req_data, resp_ready}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("resp_ready", 64'(resp_ready), 64'd1);

    // IDCODE after five TMS=1 clocks
    repeat (5) move(1'b1);
    move(1'b0);
    pat = {32'($urandom), 32'($urandom)};
    shift_dr(32, pat, got);
    check("idcode", got, {32'b0, IDCODE});

    // BYPASS: one TCK of delay, captured bit 0
    shift_ir(5'h1f);
    shift_dr(8, 64'hA5, got);
    check("bypass_a5", got, 64'h4A);
    pat = 64'($urandom_range(0, 16'hffff));
    shift_dr(16, pat, got);
    check("bypass_rand", got, (pat << 1) & 64'hffff);
    shift_ir(5'h05);
    pat = 64'($urandom_range(0, 12'hfff));
    shift_dr(12, pat, got);
    check("bypass_unknown_ir", got, (pat << 1) & 64'hfff);

    // DTMCS read
    shift_ir(5'h10);
    dtmcs_scan(32'h0, "dtmcs_idle");

    // DMI write and read
    shift_ir(5'h11);
    dmi_scan(7'h10, 32'h0000_0001, 2'd2, "dmi_cap_write");
    serve(3, $urandom, 1'b0);
    dmi_scan(7'h11, 32'h0, 2'd1, "dmi_cap_read");
    serve(1, 32'hDEAD_BEEF, 1'b0);
    dmi_scan(7'h0, 32'h0, 2'd0, "dmi_cap_deadbeef");
    check("deadbeef_model", 64'(m_rdata), 64'hDEAD_BEEF);

    // Randomized DMI traffic
    for (int k = 0; k < 4; k++) begin
      dmi_scan(7'($urandom), $urandom, 2'($urandom_range(1, 2)), "dmi_rand");
      serve(int'($urandom_range(0, 4)), $urandom, 1'b0);
    end
    dmi_scan(7'h0, 32'h0, 2'd0, "dmi_rand_final");

    // Busy: scans while a request is outstanding
    dmi_scan(7'h22, $urandom, 2'd2, "busy_issue");
    dmi_scan(7'($urandom), $urandom, 2'd1, "busy_cap1");
    dmi_scan(7'($urandom), $urandom, 2'd2, "busy_cap2");
    serve(0, $urandom, 1'b0);
    dmi_scan(7'h0, 32'h0, 2'd0, "busy_sticky");
    shift_ir(5'h10);
    dtmcs_scan(32'h0, "dtmcs_busy");
    dtmcs_scan(32'h0001_0000, "dtmcs_reset_wr");
    dtmcs_scan(32'h0, "dtmcs_cleared");
    shift_ir(5'h11);
    dmi_scan(7'h0, 32'h0, 2'd0, "dmi_after_clear");

    // Error response and sticky blocking
    dmi_scan(7'($urandom), 32'h0, 2'd1, "err_issue");
    serve(2, $urandom, 1'b1);
    dmi_scan(7'h0, 32'h0, 2'd0, "err_sticky");
    dmi_scan(7'h33, $urandom, 2'd2, "err_blocked_scan");
    repeat (4) @(negedge clk);
    check("sticky_blocks", 64'(req_valid), 64'd0);
    shift_ir(5'h10);
    dtmcs_scan(32'h0, "dtmcs_failed");
    dtmcs_scan(32'h0002_0000, "dtmcs_hard_wr");

    // dmihardreset drops an outstanding request
    shift_ir(5'h11);
    dmi_scan(7'($urandom), $urandom, 2'd2, "hard_issue");
    check("hard_pending", 64'(req_valid), 64'd1);
    shift_ir(5'h10);
    dtmcs_scan(32'h0002_0000, "dtmcs_hard_drop");
    repeat (2) @(negedge clk);
    check("hard_dropped", 64'(req_valid), 64'd0);
    shift_ir(5'h11);
    dmi_scan(7'h0, 32'h0, 2'd0, "after_hard");

    // trst_n mid Shift-DR resets the TAP but not the issued request
    dmi_scan(7'($urandom), $urandom, 2'd2, "trst_issue");
    shift_ir(5'h1f);
    move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, 1'b1, d);
    trst_n = 1'b0;
    repeat (6) @(negedge clk);
    trst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("trst_tdo_oe", 64'(tdo_oe), 64'd0);
    move(1'b0);
    shift_dr(32, {32'($urandom), 32'($urandom)}, got);
    check("trst_idcode", got, {32'b0, IDCODE});
    check("trst_req_kept", 64'(req_valid), 64'd1);
    serve(1, $urandom, 1'b0);
    shift_ir(5'h11);
    dmi_scan(7'h0, 32'h0, 2'd0, "trst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
